// File: rtl/uart_pkg.sv
// Shared types and constants for the inverted-line UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Default number of data bits per frame.
  localparam int DATA_BITS_DEF = 8;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_tick_detect.sv
// Rising-edge detector turning the bit_clk square wave into a one-cycle tick.
// Latency: tick is asserted in the first ref_clk cycle where bit_clk is seen high.
// Backpressure: none; one tick per bit_clk rising edge, never stalls.
//
// Ports:
//   ref_clk - system clock
//   reset   - synchronous, active-high
//   bit_clk - bit-rate square wave, synchronous to ref_clk (sampled, not a clock)
//   tick    - high for one ref_clk cycle per bit_clk rising edge
module uart_tick_detect (
  input  logic ref_clk,
  input  logic reset,
  input  logic bit_clk,
  output logic tick
);

  logic bit_clk_q;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      bit_clk_q <= 1'b0;
    end else begin
      bit_clk_q <= bit_clk;
    end
  end

  // bit_clk is already synchronous to ref_clk, so no synchroniser is needed.
  assign tick = bit_clk & ~bit_clk_q;

endmodule

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter, inverted line (idle/stop 0, start 1, data complemented, LSB first).
// Latency: start bit goes out on the first bit tick after the accept cycle; one bit per tick after that.
// Backpressure: busy high from accept through the stop bit; send is ignored while busy.
//
// Ports:
//   ref_clk - system clock, all state on rising edge
//   reset   - synchronous, active-high; aborts any frame in flight
//   bit_clk - bit-rate square wave, used only as a rising-edge tick
//   send    - level request, held by the producer until busy rises
//   in      - byte to send, sampled on the accept cycle only
//   busy    - registered, high from accept to end of stop bit
//   out     - registered serial line, inverted polarity
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 ref_clk,
  input  logic                 reset,
  input  logic                 bit_clk,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] in,
  output logic                 busy,
  output logic                 out
);

  localparam int CW = $clog2(DATA_BITS + 1);

  logic                 tick;
  state_t               state;
  state_t               state_nxt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 out_nxt;
  logic                 busy_nxt;

  uart_tick_detect u_tick (
    .ref_clk (ref_clk),
    .reset   (reset),
    .bit_clk (bit_clk),
    .tick    (tick)
  );

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      count <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      count <= count_nxt;
      out   <= out_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    count_nxt = count;
    out_nxt   = out;
    busy_nxt  = busy;

    unique case (state)
      IDLE: begin
        out_nxt  = 1'b0;
        busy_nxt = 1'b0;
        // A tick coinciding with the accept cycle is deliberately dropped:
        // WAIT_TICK lines the start bit up with a full bit period.
        if (send) begin
          shift_nxt = in;
          busy_nxt  = 1'b1;
          state_nxt = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (tick) begin
          out_nxt   = 1'b1;
          state_nxt = START;
        end
      end

      START: begin
        if (tick) begin
          out_nxt   = ~shift[0];
          shift_nxt = shift >> 1;
          count_nxt = CW'(1);
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          // count holds the number of data bits already on the line.
          if (count < CW'(DATA_BITS)) begin
            out_nxt   = ~shift[0];
            shift_nxt = shift >> 1;
            count_nxt = count + CW'(1);
          end else begin
            out_nxt   = 1'b0;
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        // Stop level is already 0; the tick ending it releases busy.
        if (tick) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: frame-level reference model, per-cycle output compare,
// bit_clk-edge frame decoder and a few literal expectations.
module tb_uart_tx;

  localparam int DB        = 8;
  localparam int FRAME_LEN = DB + 2;
  localparam int HALF_BIT  = 4;   // ref_clk cycles per bit_clk half period
  localparam int BIT_CYC   = 2 * HALF_BIT;

  logic          ref_clk  = 1'b0;
  logic          reset    = 1'b1;
  logic          bit_clk  = 1'b0;
  logic          send     = 1'b0;
  logic [DB-1:0] din      = '0;
  logic          busy;
  logic          out_line;

  uart_tx #(.DATA_BITS(DB)) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .bit_clk (bit_clk),
    .send    (send),
    .in      (din),
    .busy    (busy),
    .out     (out_line)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    forever begin
      repeat (HALF_BIT) @(posedge ref_clk);
      #1 bit_clk = ~bit_clk;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: expected line levels of a frame held in an array,
  // walked one entry per bit tick.
  logic          m_busy = 1'b0;
  logic          m_out  = 1'b0;
  logic          m_bcq  = 1'b0;
  int            m_pos  = 0;
  logic          m_frame [FRAME_LEN];
  logic [DB-1:0] exp_q [$];

  // Frame decoder driven by samples taken on bit_clk rising edges.
  int            dstate     = 0;
  logic [DB-1:0] draw       = '0;
  logic [DB-1:0] last_raw   = '0;
  logic          bc_last    = 1'b0;
  int            frames_dec = 0;
  logic          chk_en     = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at each negedge. Inputs seen here are the values the DUT will
  // sample on the coming posedge, so the model is advanced after comparing.
  task automatic monitor_step();
    logic tick_m;
    if (chk_en) begin
      check1("out_cycle", out_line, m_out);
      check1("busy_cycle", busy, m_busy);
    end

    if (chk_en && bit_clk && !bc_last) begin
      if (dstate == 0) begin
        if (out_line === 1'b1) dstate = 1;
      end else if (dstate <= DB) begin
        draw[dstate-1] = out_line;
        dstate++;
      end else begin
        check1("stop_bit", out_line, 1'b0);
        check1("busy_at_stop_sample", busy, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got raw %02h, expected no frame at %0t", draw, $time);
        end else begin
          check8("frame_byte", ~draw, exp_q.pop_front());
        end
        last_raw = draw;
        frames_dec++;
        dstate = 0;
      end
    end
    bc_last = bit_clk;

    tick_m = bit_clk & ~m_bcq;
    m_bcq  = reset ? 1'b0 : bit_clk;
    if (reset) begin
      m_busy = 1'b0;
      m_out  = 1'b0;
      m_pos  = 0;
      exp_q.delete();
      dstate = 0;
    end else if (!m_busy) begin
      m_out = 1'b0;
      if (send) begin
        m_busy     = 1'b1;
        m_pos      = 0;
        m_frame[0] = 1'b1;
        for (int i = 0; i < DB; i++) m_frame[i+1] = ~din[i];
        m_frame[FRAME_LEN-1] = 1'b0;
        exp_q.push_back(din);
      end
    end else if (tick_m) begin
      m_pos++;
      if (m_pos <= FRAME_LEN) m_out = m_frame[m_pos-1];
      else m_busy = 1'b0;
    end
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge ref_clk);
      #1;
      if (busy === level) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: busy never reached %b within %0d cycles", name, level, budget);
  endtask

  task automatic send_frame(input logic [DB-1:0] b);
    wait_busy(1'b0, 400, "send_wait_idle");
    send = 1'b1;
    din  = b;
    wait_busy(1'b1, 10, "send_wait_accept");
    send = 1'b0;
    din  = DB'($urandom);
  endtask

  logic [DB-1:0] b2b [5];

  initial begin
    b2b[0] = 8'hCA; b2b[1] = 8'hA1; b2b[2] = 8'hB2; b2b[3] = 8'hC3; b2b[4] = 8'h4B;

    fork
      forever begin
        @(negedge ref_clk);
        monitor_step();
      end
    join_none

    // Reset state.
    reset = 1'b1;
    repeat (4) @(posedge ref_clk);
    #1;
    chk_en = 1'b1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_out", out_line, 1'b0);

    // Idle with a byte on the bus but no request.
    reset = 1'b0;
    din   = 8'hA9;
    repeat (3 * BIT_CYC) @(posedge ref_clk);
    #1;
    check1("idle_busy", busy, 1'b0);
    check1("idle_out", out_line, 1'b0);

    // Single frame: line bits LSB first are ~A9 = 56.
    send_frame(8'hA9);
    wait_busy(1'b0, 400, "a9_end");
    check8("a9_raw_line_bits", last_raw, 8'h56);
    check_int("frames_after_a9", frames_dec, 1);

    // Back-to-back frames, send dropped at busy rise and re-raised at once.
    send = 1'b1;
    din  = b2b[0];
    for (int i = 0; i < 5; i++) begin
      wait_busy(1'b1, 400, "b2b_accept");
      send = 1'b0;
      @(posedge ref_clk);
      #1;
      if (i < 4) begin
        din  = b2b[i+1];
        send = 1'b1;
      end
      wait_busy(1'b0, 400, "b2b_end");
    end
    check8("b2b_last_raw", last_raw, 8'hB4);
    check_int("frames_after_b2b", frames_dec, 6);

    // Extra send mid-frame with a different byte is ignored.
    send_frame(8'h55);
    repeat (3 * BIT_CYC) @(posedge ref_clk);
    #1;
    din  = 8'hFF;
    send = 1'b1;
    @(posedge ref_clk);
    #1;
    send = 1'b0;
    wait_busy(1'b0, 400, "mid_end");
    check8("mid_raw", last_raw, 8'hAA);
    check_int("frames_after_mid", frames_dec, 7);

    // Reset around data bit 4 aborts the frame on the next edge.
    send_frame(8'h96);
    repeat (6) @(posedge bit_clk);
    repeat (3) @(posedge ref_clk);
    #1;
    check1("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge ref_clk);
    #1;
    reset = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_out", out_line, 1'b0);
    repeat (2 * BIT_CYC) @(posedge ref_clk);
    send_frame(8'h3C);
    wait_busy(1'b0, 400, "post_reset_end");
    check8("post_reset_raw", last_raw, 8'hC3);
    check_int("frames_after_reset", frames_dec, 8);

    // Random bytes with random gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge ref_clk);
      #1;
      send_frame(DB'($urandom));
    end
    wait_busy(1'b0, 400, "rand_end");

    // Final idle.
    repeat (4 * BIT_CYC) @(posedge ref_clk);
    #1;
    check1("final_busy", busy, 1'b0);
    check1("final_out", out_line, 1'b0);
    check_int("pending_frames", exp_q.size(), 0);
    check_int("frames_total", frames_dec, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
